// File: rtl/io_out_fifo_pkg.sv
// io_out_fifo_pkg: width helpers and entry packing shared by the output FIFO slice
package io_out_fifo_pkg;

    // Port address width, never narrower than one bit
    function automatic int addr_w(input int nuioou);
        return (nuioou > 2) ? $clog2(nuioou) : 1;
    endfunction

    // Pointer width, never narrower than one bit
    function automatic int ptr_w(input int fdepth);
        return (fdepth > 2) ? $clog2(fdepth) : 1;
    endfunction

    // Fill-level width, able to hold the value fdepth
    function automatic int cnt_w(input int fdepth);
        return $clog2(fdepth + 1);
    endfunction

    // Stored entry width: {addr, data}
    function automatic int ent_w(input int nubits, input int nuioou);
        return addr_w(nuioou) + nubits;
    endfunction

    // Widest entry the helpers below can carry
    localparam int MAX_EW = 64;

    // Places the address directly above the data word
    function automatic logic [MAX_EW-1:0] pack_entry(input logic [MAX_EW-1:0] addr,
                                                    input logic [MAX_EW-1:0] data,
                                                    input int nubits);
        return (addr << nubits) | data;
    endfunction

    // Recovers the address field from a packed entry
    function automatic logic [MAX_EW-1:0] unpack_addr(input logic [MAX_EW-1:0] ent,
                                                     input int nubits);
        return ent >> nubits;
    endfunction

endpackage

// File: rtl/io_out_fifo_if.sv
// io_out_fifo_if: processor-write and consumer-handshake bundle of the output FIFO (itr_req under IO_OUT_FIFO_ITR_EN)
interface io_out_fifo_if #(
    parameter int NUBITS = 16,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 8
);
    localparam int AW = io_out_fifo_pkg::addr_w(NUIOOU);
    localparam int CW = io_out_fifo_pkg::cnt_w(FDEPTH);

    logic [NUBITS-1:0] io_out;
    logic [AW-1:0]     addr_out;
    logic              out_en;
    logic [NUBITS-1:0] dout_data;
    logic [AW-1:0]     dout_addr;
    logic              dout_valid;
    logic              dout_ready;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              ovf;
`ifdef IO_OUT_FIFO_ITR_EN
    logic              itr_req;
`endif

    modport slave (
        input  io_out, addr_out, out_en, dout_ready,
        output dout_data, dout_addr, dout_valid, full, empty, count, ovf
`ifdef IO_OUT_FIFO_ITR_EN
        , output itr_req
`endif
    );

    modport master (
        output io_out, addr_out, out_en, dout_ready,
        input  dout_data, dout_addr, dout_valid, full, empty, count, ovf
`ifdef IO_OUT_FIFO_ITR_EN
        , input itr_req
`endif
    );
endinterface

// File: rtl/io_out_fifo_ram.sv
// fifo_ram: entry storage with a synchronous write port and an asynchronous read port
module fifo_ram #(
    parameter int EW = 17,
    parameter int FDEPTH = 8,
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [EW-1:0] wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [EW-1:0] rdata_o
);
    logic [EW-1:0] mem_q [FDEPTH];

    // Write the entry at the write pointer; storage is not reset, pointers make it invisible
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/io_out_fifo.sv
// io_out_fifo: show-ahead FIFO between processor output writes and a valid/ready consumer (optional itr_req via IO_OUT_FIFO_ITR_EN)
module io_out_fifo
    import io_out_fifo_pkg::*;
#(
    parameter int NUBITS = 16,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 8,
    parameter int FTHRES = 6
) (
    input logic clk,
    input logic rst,
    io_out_fifo_if.slave bus
);
    localparam int AW = addr_w(NUIOOU);
    localparam int PW = ptr_w(FDEPTH);
    localparam int CW = cnt_w(FDEPTH);
    localparam int EW = ent_w(NUBITS, NUIOOU);

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, push;
    logic [EW-1:0] wr_ent, rd_ent;

    assign wr_ent = EW'(pack_entry(MAX_EW'(bus.addr_out), MAX_EW'(bus.io_out), NUBITS));

    // Handshake decode, wrapping pointer advance, fill level and sticky overflow
    always_comb begin
        empty = (cnt_q == '0);
        full  = (cnt_q == CW'(FDEPTH));
        pop   = !empty & bus.dout_ready;
        push  = bus.out_en & (!full | pop);
        wr_d  = push ? ((wr_q == PW'(FDEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d  = pop ? ((rd_q == PW'(FDEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = (push & !pop) ? cnt_q + 1'b1 : (pop & !push) ? cnt_q - 1'b1 : cnt_q;
        ovf_d = ovf_q | (bus.out_en & !push);
    end

    // State registers; reset discards all entries and clears the overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    fifo_ram #(.EW(EW), .FDEPTH(FDEPTH), .PW(PW)) u_ram (
        .clk     (clk),
        .we_i    (push & !rst),
        .waddr_i (wr_q),
        .wdata_i (wr_ent),
        .raddr_i (rd_q),
        .rdata_o (rd_ent)
    );

    assign bus.dout_valid = !empty;
    assign bus.dout_data  = empty ? '0 : rd_ent[NUBITS-1:0];
    assign bus.dout_addr  = empty ? '0 : AW'(unpack_addr(MAX_EW'(rd_ent), NUBITS));
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = cnt_q;
    assign bus.ovf        = ovf_q;

`ifdef IO_OUT_FIFO_ITR_EN
    logic itr_q;

    // Threshold request follows the registered fill level one cycle later
    always_ff @(posedge clk) begin
        if (rst) itr_q <= 1'b0;
        else     itr_q <= (cnt_q >= CW'(FTHRES));
    end

    assign bus.itr_req = itr_q;
`endif
endmodule
